gcd_stein_core: RTL

Parametrised binary (Stein) GCD engine with valid/ready handshakes on both the operand and result sides. It replaces the subtract-only GCD controller/datapath pair with one self-sequenced block. Each iteration uses only shifts and one subtraction. Zero operands take a single-cycle bypass. Each result reports how many iterations it took. It sits between an operand producer and a result consumer, and either side may stall.

---
 rtl/gcd_stein_core.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/gcd_stein_core.sv
// Binary (Stein) GCD engine with valid/ready handshakes on the operand and result sides.
// Each iteration uses only shifts and one subtraction; zero operands take a single-cycle bypass.
module gcd_stein_core #(
  parameter  int DATA_WIDTH = 32,
  localparam int K_WIDTH    = $clog2(DATA_WIDTH + 1),
  localparam int ITER_WIDTH = $clog2(2 * DATA_WIDTH + 1)
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic [DATA_WIDTH-1:0] operand_a_i,
  input  logic [DATA_WIDTH-1:0] operand_b_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic                  abort_i,
  output logic [DATA_WIDTH-1:0] gcd_o,
  output logic [ITER_WIDTH-1:0] iter_o,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic                  busy_o
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REDUCE = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  state_e                  state_q;
  logic [DATA_WIDTH-1:0]   a_q, b_q, a_d, b_d;
  logic [K_WIDTH-1:0]      k_q, k_d;
  logic [ITER_WIDTH-1:0]   iter_q, iter_d;
  logic [DATA_WIDTH-1:0]   gcd_q;
  logic [ITER_WIDTH-1:0]   iter_out_q;
  logic                    valid_q;
  logic                    busy_q;
  logic                    zero_s;
  logic [DATA_WIDTH-1:0]   gcd_shift_s;
  logic [DATA_WIDTH-1:0]   diff_s;

  // One Stein reduction step applied to the working pair.
  always_comb begin
    a_d         = a_q;
    b_d         = b_q;
    k_d         = k_q;
    iter_d      = iter_q + ITER_WIDTH'(1);
    zero_s      = (a_q == '0) || (b_q == '0);
    gcd_shift_s = (a_q | b_q) << k_q;
    if (a_q >= b_q) begin
      diff_s = a_q - b_q;
    end else begin
      diff_s = b_q - a_q;
    end
    case ({a_q[0], b_q[0]})
      2'b00: begin
        a_d = a_q >> 1;
        b_d = b_q >> 1;
        k_d = k_q + K_WIDTH'(1);
      end
      2'b01: a_d = a_q >> 1;
      2'b10: b_d = b_q >> 1;
      default: begin
        if (a_q >= b_q) begin
          a_d = diff_s >> 1;
        end else begin
          b_d = diff_s >> 1;
        end
      end
    endcase
  end

  // Control FSM with registered result and status outputs; abort outranks everything but reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= ST_IDLE;
      a_q        <= '0;
      b_q        <= '0;
      k_q        <= '0;
      iter_q     <= '0;
      gcd_q      <= '0;
      iter_out_q <= '0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else if (abort_i) begin
      state_q <= ST_IDLE;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (valid_i) begin
            a_q    <= operand_a_i;
            b_q    <= operand_b_i;
            k_q    <= '0;
            iter_q <= '0;
            busy_q <= 1'b1;
            if ((operand_a_i == '0) || (operand_b_i == '0)) begin
              gcd_q      <= operand_a_i | operand_b_i;
              iter_out_q <= '0;
              valid_q    <= 1'b1;
              state_q    <= ST_DONE;
            end else begin
              state_q <= ST_REDUCE;
            end
          end
        end
        ST_REDUCE: begin
          if (zero_s) begin
            gcd_q      <= gcd_shift_s;
            iter_out_q <= iter_q;
            valid_q    <= 1'b1;
            state_q    <= ST_DONE;
          end else begin
            a_q    <= a_d;
            b_q    <= b_d;
            k_q    <= k_d;
            iter_q <= iter_d;
          end
        end
        ST_DONE: begin
          if (ready_i) begin
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign ready_o = ~reset_i && (state_q == ST_IDLE);
  assign gcd_o   = gcd_q;
  assign iter_o  = iter_out_q;
  assign valid_o = valid_q;
  assign busy_o  = busy_q;

endmodule
